// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the shared RAM (MAR/MBR path).
// Port 0 is the control unit; port 1 is the loader/debug port. Ties alternate.
module mem_arbiter #(
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          arb_clk,
    input  logic          arb_rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          last, last_d;
    logic          lat_we, lat_we_d;
    logic          gnt0_d, gnt1_d;
    logic          done0_d, done1_d;
    logic [DW-1:0] rdata_d;
    logic [AW-1:0] ram_addr_d;
    logic [DW-1:0] ram_wdata_d;
    logic          ram_we_d;
    logic          busy_d;
    logic          win0, win1;

    // State and registered outputs
    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            lat_we    <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata     <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            last      <= last_d;
            lat_we    <= lat_we_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            done0     <= done0_d;
            done1     <= done1_d;
            rdata     <= rdata_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
            ram_we    <= ram_we_d;
            busy      <= busy_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        last_d      = last;
        lat_we_d    = lat_we;
        gnt0_d      = gnt0;
        gnt1_d      = gnt1;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rdata_d     = rdata;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        ram_we_d    = 1'b0;
        // last=1 means port 1 was served most recently, so port 0 wins a tie
        win0        = req0 && (!req1 || last);
        win1        = req1 && !win0;

        unique case (state)
            IDLE: begin
                if (win0) begin
                    ram_addr_d  = addr0;
                    ram_wdata_d = wdata0;
                    lat_we_d    = we0;
                    ram_we_d    = we0;
                    last_d      = 1'b0;
                    gnt0_d      = 1'b1;
                    state_d     = ACCESS;
                end else if (win1) begin
                    ram_addr_d  = addr1;
                    ram_wdata_d = wdata1;
                    lat_we_d    = we1;
                    ram_we_d    = we1;
                    last_d      = 1'b1;
                    gnt1_d      = 1'b1;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_we) begin
                    done0_d = gnt0;
                    done1_d = gnt1;
                    state_d = DONE;
                end else begin
                    cnt_d   = CW'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    rdata_d = ram_rdata;
                    done0_d = gnt0;
                    done1_d = gnt1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            DONE: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: driver predicts grant order and data from a
// transaction-level model; a monitor pops and checks on every grant and done.
module tb_mem_arbiter;

    localparam int unsigned AW     = 8;
    localparam int unsigned DW     = 8;
    localparam int unsigned RD_LAT = 3;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          arb_clk = 1'b0;
    logic          arb_rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1, ram_we, busy;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    txn_t q0[$];
    txn_t q1[$];
    exp_t expq[$];

    logic [DW-1:0] mem [256];
    logic [DW-1:0] model_mem [256];
    logic [DW-1:0] pipe [RD_LAT];
    logic          last_m;
    logic [DW-1:0] last_rd;

    always #5 arb_clk = ~arb_clk;
    always @(posedge arb_clk) cyc <= cyc + 1;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .arb_clk(arb_clk), .arb_rst(arb_rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata), .busy(busy)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 37 + 11);
    endfunction

    // RAM with RD_LAT cycles of read latency from the address
    always @(posedge arb_clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata = pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: grant-time and done-time checks against the scoreboard
    logic pg = 1'b0;
    int   gstart = 0;
    always @(negedge arb_clk) begin
        if (!arb_rst) begin
            chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'(0));
            chk("done_exclusive", 32'(done0 & done1), 32'(0));
            chk("busy_vs_gnt", 32'(busy), 32'(gnt0 | gnt1));
            if ((gnt0 | gnt1) && !pg) begin
                gstart = cyc;
                if (expq.size() == 0) begin
                    flag("unexpected_grant");
                end else begin
                    chk("grant_port", 32'(gnt1), 32'(expq[0].port));
                    chk("ram_addr", 32'(ram_addr), 32'(expq[0].addr));
                    chk("ram_we_access", 32'(ram_we), 32'(expq[0].we));
                    if (expq[0].we) chk("ram_wdata", 32'(ram_wdata), 32'(expq[0].wdata));
                end
            end else begin
                chk("ram_we_idle", 32'(ram_we), 32'(0));
            end
            if (done0 | done1) begin
                if (expq.size() == 0) begin
                    flag("spurious_done");
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("done_port", 32'(done1), 32'(e.port));
                    chk("gnt_at_done", 32'(e.port == 1 ? gnt1 : gnt0), 32'(1));
                    chk("rdata", 32'(rdata), 32'(e.rdata));
                    chk("latency", 32'(cyc - gstart), 32'(e.we ? 1 : 1 + RD_LAT));
                end
            end
            pg = gnt0 | gnt1;
        end else begin
            pg = 1'b0;
        end
    end

    function automatic txn_t rnd_txn();
        txn_t t;
        t.we    = 1'($urandom % 2);
        t.addr  = AW'($urandom_range(0, 15));
        t.wdata = DW'($urandom);
        return t;
    endfunction

    function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        return t;
    endfunction

    // Reference model: apply one access to the model memory and queue its expectation
    task automatic model_push(input int p, input txn_t t);
        exp_t e;
        e.port = p; e.we = t.we; e.addr = t.addr; e.wdata = t.wdata;
        if (t.we) begin
            e.rdata = last_rd;
            model_mem[t.addr] = t.wdata;
        end else begin
            e.rdata = model_mem[t.addr];
            last_rd = e.rdata;
        end
        expq.push_back(e);
        last_m = 1'(p);
    endtask

    // Service order: tie goes to the port not served last; a port holding req
    // with more work alternates with the other, else continues alone
    task automatic predict();
        int n0 = q0.size();
        int n1 = q1.size();
        int i0 = 0;
        int i1 = 0;
        int p;
        if (n0 > 0 && n1 > 0) p = last_m ? 0 : 1;
        else p = (n0 > 0) ? 0 : 1;
        while (i0 < n0 || i1 < n1) begin
            if (p == 0 && i0 >= n0) p = 1;
            else if (p == 1 && i1 >= n1) p = 0;
            if (p == 0) begin model_push(0, q0[i0]); i0++; end
            else begin model_push(1, q1[i1]); i1++; end
            p = 1 - p;
        end
    endtask

    task automatic run_round(input bit early, input bit scramble, output bit ok);
        int budget;
        predict();
        @(negedge arb_clk);
        if (q0.size() > 0) begin
            we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata; req0 = 1'b1;
        end
        if (q1.size() > 0) begin
            we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata; req1 = 1'b1;
        end
        ok = 1'b0;
        budget = 0;
        while (budget < 200) begin
            @(negedge arb_clk);
            budget++;
            if (done0) begin
                void'(q0.pop_front());
                if (q0.size() > 0) begin
                    we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata;
                end else req0 = 1'b0;
            end else if (gnt0) begin
                if (early && q0.size() == 1) req0 = 1'b0;
                if (scramble) begin
                    we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = DW'($urandom);
                end
            end
            if (done1) begin
                void'(q1.pop_front());
                if (q1.size() > 0) begin
                    we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata;
                end else req1 = 1'b0;
            end else if (gnt1) begin
                if (early && q1.size() == 1) req1 = 1'b0;
                if (scramble) begin
                    we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = DW'($urandom);
                end
            end
            if (q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            flag("round_timeout");
            return;
        end
        repeat (2) @(negedge arb_clk);
        chk("idle_busy", 32'(busy), 32'(0));
        chk("scoreboard_drained", 32'(expq.size()), 32'(0));
    endtask

    task automatic reset_mid_access(output bit ok);
        int budget = 0;
        q0.push_back(mk(1'b0, AW'(8'h07), DW'(0)));
        predict();
        @(negedge arb_clk);
        we0 = 1'b0; addr0 = AW'(8'h07); req0 = 1'b1;
        ok = 1'b0;
        while (budget < 20) begin
            @(negedge arb_clk);
            budget++;
            if (gnt0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            flag("reset_test_no_grant");
            return;
        end
        @(negedge arb_clk);
        chk("pre_reset_gnt0", 32'(gnt0), 32'(1));
        chk("pre_reset_done0", 32'(done0), 32'(0));
        arb_rst = 1'b1;
        @(negedge arb_clk);
        chk("rst_gnt0", 32'(gnt0), 32'(0));
        chk("rst_gnt1", 32'(gnt1), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done0", 32'(done0), 32'(0));
        chk("rst_ram_we", 32'(ram_we), 32'(0));
        chk("rst_rdata", 32'(rdata), 32'(0));
        expq.delete();
        q0.delete();
        req0 = 1'b0;
        arb_rst = 1'b0;
        last_m = 1'b1;
        last_rd = '0;
        repeat (5) @(negedge arb_clk);
        chk("post_reset_idle", 32'(busy), 32'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
        last_m = 1'b1;
        last_rd = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        arb_rst = 1'b1;
        repeat (3) @(negedge arb_clk);
        chk("reset_gnt0", 32'(gnt0), 32'(0));
        chk("reset_gnt1", 32'(gnt1), 32'(0));
        chk("reset_done0", 32'(done0), 32'(0));
        chk("reset_done1", 32'(done1), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_ram_we", 32'(ram_we), 32'(0));
        chk("reset_ram_addr", 32'(ram_addr), 32'(0));
        chk("reset_ram_wdata", 32'(ram_wdata), 32'(0));
        chk("reset_rdata", 32'(rdata), 32'(0));
        arb_rst = 1'b0;
        ok = 1'b1;

        // Tie from reset: port 0 first, then strict alternation
        q0.push_back(mk(1'b0, AW'(8'h03), '0));
        q0.push_back(mk(1'b0, AW'(8'h04), '0));
        q1.push_back(mk(1'b0, AW'(8'h05), '0));
        q1.push_back(mk(1'b0, AW'(8'h06), '0));
        run_round(1'b0, 1'b0, ok);
        // Write on port 1 then read back on port 0
        if (ok) begin q1.push_back(mk(1'b1, AW'(8'h40), DW'(8'h3C))); run_round(1'b0, 1'b0, ok); end
        if (ok) begin q0.push_back(mk(1'b0, AW'(8'h40), '0)); run_round(1'b0, 1'b0, ok); end
        if (ok) begin q1.push_back(mk(1'b1, AW'(8'h12), DW'(8'hA5))); run_round(1'b0, 1'b0, ok); end
        if (ok) begin q0.push_back(mk(1'b0, AW'(8'h12), '0)); run_round(1'b0, 1'b1, ok); end
        // Winner drops req early; access still completes
        if (ok) begin q0.push_back(mk(1'b0, AW'(8'h07), '0)); run_round(1'b1, 1'b0, ok); end
        if (ok) reset_mid_access(ok);
        if (ok) begin
            q0.push_back(rnd_txn());
            q1.push_back(rnd_txn());
            run_round(1'b0, 1'b0, ok);
        end
        for (int r = 0; r < 40 && ok; r++) begin
            int n0 = $urandom_range(0, 3);
            int n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n0 = 1;
            for (int k = 0; k < n0; k++) q0.push_back(rnd_txn());
            for (int k = 0; k < n1; k++) q1.push_back(rnd_txn());
            run_round(1'($urandom % 2), 1'($urandom % 2), ok);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the single shared RAM (MAR/MBR path).
- Port 0 is the control unit for fetch and LD/ST. Port 1 is the external loader/debug port.
- Grants one requester at a time, round-robin on contention.
- Sequences each access as address phase, read-latency wait, then completion, and returns the read data with a one-cycle done pulse.

Parameters:
AW, 8, address width
DW, 8, data width
RD_LAT, 1, RAM read latency in cycles from the address phase to valid ram_rdata; legal range 1..15

Ports:
arb_clk  input  1  clock; all state changes on the rising edge
arb_rst  input  1  synchronous, active-high reset
req0  input  1  port 0 access request; held until done0
we0  input  1  port 0 write enable (1 = write, 0 = read)
addr0  input  AW  port 0 address
wdata0  input  DW  port 0 write data
req1, we1, addr1, wdata1  input  1/1/AW/DW  port 1 equivalents
gnt0  output  1  port 0 owns the RAM (ACCESS through DONE)
gnt1  output  1  port 1 owns the RAM
done0  output  1  one-cycle completion pulse for port 0
done1  output  1  one-cycle completion pulse for port 1
rdata  output  DW  registered read data; valid while doneX=1 and held afterwards
ram_addr  output  AW  RAM address
ram_wdata  output  DW  RAM write data
ram_we  output  1  RAM write strobe
ram_rdata  input  DW  RAM read data
busy  output  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE; gnt0=gnt1=0; done0=done1=0; ram_we=0; ram_addr=0; ram_wdata=0; rdata=0; wait counter=0; last=1, so port 0 wins the first tie.
- Reset asserted mid-access: the access is abandoned, no done is issued, and ram_we=0 from the next edge.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: that port wins.
  - Both req: the port != last wins.
  - On the winning edge: latch winner's addr/wdata/we into ram_addr/ram_wdata/lat_we, set last=winner, assert gntWinner, go to ACCESS.
- ACCESS (1 cycle):
  - ram_we=lat_we for this cycle only.
  - Write: next state DONE.
  - Read: load counter with RD_LAT-1, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0: capture ram_rdata into rdata, go to DONE.
  - WAIT lasts exactly RD_LAT cycles.
- DONE (1 cycle):
  - doneWinner=1.
  - rdata is unchanged for writes.
  - Next state IDLE; gnt is cleared on leaving DONE.
- Latency, counting the cycle the req is sampled in IDLE as cycle 0:
  - Write: done at cycle 2.
  - Read: done at cycle 2+RD_LAT (cycle 3 at default).
  - No back-to-back overlap: minimum 1 IDLE cycle between accesses.
- Request rules:
  - Requesters hold req/we/addr/wdata until done.
  - A req still high in the IDLE cycle after done is a new request.
  - Under contention the other port wins, giving strict alternation.
- A winner dropping req before done does not abort; the access completes and done still pulses.
- Loser inputs are ignored while busy; changes to the winner's inputs after latching have no effect.
- gnt0 and gnt1 are never both 1; done0 and done1 are never both 1.
- ram_addr and ram_wdata hold their last value in IDLE; ram_we=0 outside ACCESS.
- Counter width is 4 bits.

Test Plan:
- Single read, port 0: RAM[0x12]=0xA5, req0=1 we0=0 addr0=0x12 at cycle 0 -> gnt0=1 cycles 1-3, ram_we=0 throughout, done0=1 at cycle 3 only, rdata=0xA5.
- Single write, port 1: req1=1 we1=1 addr1=0x40 wdata1=0x3C -> ram_we=1 only at cycle 1 with ram_addr=0x40 ram_wdata=0x3C, done1 at cycle 2, a following read of 0x40 returns 0x3C.
- Contention with req0=req1=1 held continuously, 4 reads -> grants port 0,1,0,1, with gnt never overlapping and one IDLE cycle between accesses.
- RD_LAT=3 build, read addr 0x07 holding 0x5E -> WAIT for 3 cycles, done0 at cycle 5, rdata=0x5E.
- Reset mid-access: arb_rst=1 during WAIT -> next edge state IDLE, gnt=0, done never pulses, ram_we=0; after release a tie grants port 0.
- Early req drop: req0 deasserted at cycle 2 of a read -> done0 still pulses at cycle 3, and the next IDLE cycle grants nothing if no req is pending.
